// File: rtl/dram_arbiter_pkg.sv
// Shared definitions for the DDR2 controller arbiter: command codes and FSM states.
package dram_arbiter_pkg;

    localparam logic [2:0] DRAM_CMD_WRITE = 3'b000;
    localparam logic [2:0] DRAM_CMD_READ  = 3'b001;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WR_BEAT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dram_arbiter_if.sv
// Requester-side and controller-side bus of the arbiter, bundled as one interface.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dram_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 31,
    parameter int DATA_W    = 144,
    parameter int MASK_W    = 18
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_rnw;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_wr_data;
    logic [NUM_PORTS*MASK_W-1:0] req_wr_mask;
    logic [NUM_PORTS-1:0]        req_ack;
    logic [NUM_PORTS-1:0]        rd_valid;
    logic [DATA_W-1:0]           rd_data;
    logic                        app_af_wren;
    logic [2:0]                  app_af_cmd;
    logic [ADDR_W-1:0]           app_af_addr;
    logic                        app_af_afull;
    logic                        app_wdf_wren;
    logic [DATA_W-1:0]           app_wdf_data;
    logic [MASK_W-1:0]           app_wdf_mask_data;
    logic                        app_wdf_afull;
    logic                        ctrl_rd_valid;
    logic [DATA_W-1:0]           ctrl_rd_data;

    modport slave (
        input  req_valid, req_rnw, req_addr, req_wr_data, req_wr_mask,
        input  app_af_afull, app_wdf_afull, ctrl_rd_valid, ctrl_rd_data,
        output req_ack, rd_valid, rd_data,
        output app_af_wren, app_af_cmd, app_af_addr,
        output app_wdf_wren, app_wdf_data, app_wdf_mask_data
    );

    modport master (
        output req_valid, req_rnw, req_addr, req_wr_data, req_wr_mask,
        output app_af_afull, app_wdf_afull, ctrl_rd_valid, ctrl_rd_data,
        input  req_ack, rd_valid, rd_data,
        input  app_af_wren, app_af_cmd, app_af_addr,
        input  app_wdf_wren, app_wdf_data, app_wdf_mask_data
    );
endinterface

// File: rtl/dram_arbiter_tag_fifo.sv
// Synchronous FIFO of requester indices for reads in flight; head is readable
// combinationally so a returning beat can be steered in the same cycle.
module dram_arbiter_tag_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    // A push into a full FIFO is accepted only when a pop frees the slot that same cycle.
    assign push_ok = push_i & (~full_o | pop_ok);
    assign data_o  = mem_q[rd_ptr_q];

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers and count; reset empties the FIFO and discards stale tags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible through the count.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one DDR2 controller user interface among NUM_PORTS
// requesters; read returns are steered back to their issuer through a tag FIFO.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 31,
    parameter int DATA_W      = 144,
    parameter int MASK_W      = 18,
    parameter int BURST_BEATS = 2,
    parameter int TAG_DEPTH   = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dram_arbiter_if.slave bus,
    output logic          err_rd_orphan_o
);
    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(BURST_BEATS + 1);

    arb_state_e           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     own_q, own_d;
    logic [CNT_W-1:0]     wr_left_q, wr_left_d;
    logic [CNT_W-1:0]     rd_beat_q, rd_beat_d;

    logic                 af_wren_q, af_wren_d;
    logic [2:0]           af_cmd_q, af_cmd_d;
    logic [ADDR_W-1:0]    af_addr_q, af_addr_d;
    logic                 wdf_wren_q, wdf_wren_d;
    logic [DATA_W-1:0]    wdf_data_q, wdf_data_d;
    logic [MASK_W-1:0]    wdf_mask_q, wdf_mask_d;
    logic [NUM_PORTS-1:0] rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 err_q, err_d;

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] ack;
    logic                 grant_valid;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W:0]       grant_cand;
    logic                 tag_push, tag_pop, tag_full, tag_empty;
    logic [PTR_W-1:0]     tag_head;

    logic [ADDR_W-1:0]    port_addr [NUM_PORTS];
    logic [DATA_W-1:0]    port_data [NUM_PORTS];
    logic [MASK_W-1:0]    port_mask [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_addr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign port_data[gi] = bus.req_wr_data[gi*DATA_W +: DATA_W];
            assign port_mask[gi] = bus.req_wr_mask[gi*MASK_W +: MASK_W];
            // Headroom for the whole command is checked up front so a write burst never stalls on afull.
            assign eligible[gi]  = bus.req_valid[gi] & ~bus.app_af_afull &
                                   (bus.req_rnw[gi] ? ~tag_full : ~bus.app_wdf_afull);
        end
    endgenerate

    // Cyclic search for the first eligible port at or after the priority pointer.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_cand  = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            grant_cand = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (grant_cand >= (PTR_W+1)'(NUM_PORTS)) grant_cand = grant_cand - (PTR_W+1)'(NUM_PORTS);
            if (eligible[grant_cand[PTR_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = grant_cand[PTR_W-1:0];
            end
        end
    end

    // FSM next state, acks, command/write-data register inputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        own_d      = own_q;
        wr_left_d  = wr_left_q;
        ack        = '0;
        tag_push   = 1'b0;
        af_wren_d  = 1'b0;
        af_cmd_d   = af_cmd_q;
        af_addr_d  = af_addr_q;
        wdf_wren_d = 1'b0;
        wdf_data_d = wdf_data_q;
        wdf_mask_d = wdf_mask_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    ack[grant_idx] = 1'b1;
                    ptr_d     = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
                    af_wren_d = 1'b1;
                    af_addr_d = port_addr[grant_idx];
                    if (bus.req_rnw[grant_idx]) begin
                        af_cmd_d = DRAM_CMD_READ;
                        tag_push = 1'b1;
                    end else begin
                        af_cmd_d   = DRAM_CMD_WRITE;
                        wdf_wren_d = 1'b1;
                        wdf_data_d = port_data[grant_idx];
                        wdf_mask_d = port_mask[grant_idx];
                        own_d      = grant_idx;
                        wr_left_d  = CNT_W'(BURST_BEATS - 1);
                        if (BURST_BEATS > 1) state_d = ST_WR_BEAT;
                    end
                end
            end
            ST_WR_BEAT: begin
                if (bus.req_valid[own_q]) begin
                    ack[own_q] = 1'b1;
                    wdf_wren_d = 1'b1;
                    wdf_data_d = port_data[own_q];
                    wdf_mask_d = port_mask[own_q];
                    wr_left_d  = wr_left_q - 1'b1;
                    if (wr_left_q == CNT_W'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read return steering: route beats to the tag at the head, pop after a full burst.
    always_comb begin
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        rd_beat_d  = rd_beat_q;
        err_d      = err_q;
        tag_pop    = 1'b0;
        if (bus.ctrl_rd_valid) begin
            if (tag_empty) begin
                err_d = 1'b1;
            end else begin
                rd_valid_d[tag_head] = 1'b1;
                rd_data_d = bus.ctrl_rd_data;
                if (rd_beat_q == CNT_W'(BURST_BEATS - 1)) begin
                    tag_pop   = 1'b1;
                    rd_beat_d = '0;
                end else begin
                    rd_beat_d = rd_beat_q + 1'b1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            own_q      <= '0;
            wr_left_q  <= '0;
            rd_beat_q  <= '0;
            af_wren_q  <= 1'b0;
            af_cmd_q   <= '0;
            af_addr_q  <= '0;
            wdf_wren_q <= 1'b0;
            wdf_data_q <= '0;
            wdf_mask_q <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            own_q      <= own_d;
            wr_left_q  <= wr_left_d;
            rd_beat_q  <= rd_beat_d;
            af_wren_q  <= af_wren_d;
            af_cmd_q   <= af_cmd_d;
            af_addr_q  <= af_addr_d;
            wdf_wren_q <= wdf_wren_d;
            wdf_data_q <= wdf_data_d;
            wdf_mask_q <= wdf_mask_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    dram_arbiter_tag_fifo #(
        .WIDTH (PTR_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tag_push),
        .data_i  (grant_idx),
        .pop_i   (tag_pop),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    // Ack is combinational; hold it low while reset is asserted so nothing is consumed.
    assign bus.req_ack           = ack & {NUM_PORTS{~rst_i}};
    assign bus.rd_valid          = rd_valid_q;
    assign bus.rd_data           = rd_data_q;
    assign bus.app_af_wren       = af_wren_q;
    assign bus.app_af_cmd        = af_cmd_q;
    assign bus.app_af_addr       = af_addr_q;
    assign bus.app_wdf_wren      = wdf_wren_q;
    assign bus.app_wdf_data      = wdf_data_q;
    assign bus.app_wdf_mask_data = wdf_mask_q;
    assign err_rd_orphan_o       = err_q;

endmodule
